// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader feeding the CPU instruction memory.
// Parses frames of the form SYNC, N, N x {hi, lo}, CSUM (XOR of all word bytes),
// writes each assembled 16-bit word to consecutive addresses starting at 0 and
// holds the CPU in reset until a whole frame with a matching checksum is written.
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   in_valid, in_data     incoming byte stream
//   in_ready              loader accepts a byte (always 1, never stalls)
//   mem_we, mem_addr,     one-cycle write strobe, address and {hi,lo} data
//   mem_wdata               towards instr_mem
//   cpu_reset             1 holds the CPU in reset
//   done, error           last frame accepted / rejected
module imem_loader #(
  parameter int unsigned ADDR_W    = 4,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  // One extra bit so a count of DEPTH words is representable without wrap.
  localparam int unsigned CNT_W = ADDR_W + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_COUNT = 3'd1;
  localparam logic [2:0] S_HI    = 3'd2;
  localparam logic [2:0] S_LO    = 3'd3;
  localparam logic [2:0] S_CSUM  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

  logic [2:0]        state_q,     state_d;
  logic [CNT_W-1:0]  n_q,         n_d;
  logic [CNT_W-1:0]  ctr_q,       ctr_d;
  logic [7:0]        csum_q,      csum_d;
  logic [7:0]        hi_q,        hi_d;
  logic              in_ready_q,  in_ready_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [15:0]       mem_wdata_q, mem_wdata_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              done_q,      done_d;
  logic              error_q,     error_d;

  logic             xfer;
  logic             n_ok;
  logic [CNT_W-1:0] ctr_inc;

  assign xfer    = in_valid & in_ready_q;
  assign n_ok    = (in_data != 8'd0) && (32'(in_data) <= DEPTH);
  assign ctr_inc = ctr_q + CNT_W'(1);

  // Next-state and registered-output logic; every register holds by default.
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    ctr_d       = ctr_q;
    csum_d      = csum_q;
    hi_d        = hi_q;
    in_ready_d  = 1'b1;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_reset_d = cpu_reset_q;
    done_d      = done_q;
    error_d     = error_q;

    if (xfer) begin
      case (state_q)
        S_IDLE: begin
          if (in_data == SYNC_BYTE) state_d = S_COUNT;
        end
        S_COUNT: begin
          if (n_ok) begin
            n_d     = CNT_W'(in_data);
            ctr_d   = '0;
            csum_d  = 8'd0;
            state_d = S_HI;
          end else begin
            error_d     = 1'b1;
            done_d      = 1'b0;
            cpu_reset_d = 1'b1;
            state_d     = S_ERR;
          end
        end
        S_HI: begin
          hi_d    = in_data;
          csum_d  = csum_q ^ in_data;
          state_d = S_LO;
        end
        S_LO: begin
          csum_d      = csum_q ^ in_data;
          mem_we_d    = 1'b1;
          mem_addr_d  = ctr_q[ADDR_W-1:0];
          mem_wdata_d = {hi_q, in_data};
          ctr_d       = ctr_inc;
          state_d     = (ctr_inc == n_q) ? S_CSUM : S_HI;
        end
        S_CSUM: begin
          if (in_data == csum_q) begin
            done_d      = 1'b1;
            error_d     = 1'b0;
            cpu_reset_d = 1'b0;
            state_d     = S_DONE;
          end else begin
            done_d      = 1'b0;
            error_d     = 1'b1;
            cpu_reset_d = 1'b1;
            state_d     = S_ERR;
          end
        end
        S_DONE, S_ERR: begin
          // Only a sync byte restarts; it re-holds the CPU and clears status.
          if (in_data == SYNC_BYTE) begin
            cpu_reset_d = 1'b1;
            done_d      = 1'b0;
            error_d     = 1'b0;
            state_d     = S_COUNT;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers; reset drops any pending write strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      ctr_q       <= '0;
      csum_q      <= 8'd0;
      hi_q        <= 8'd0;
      in_ready_q  <= 1'b1;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 16'd0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      ctr_q       <= ctr_d;
      csum_q      <= csum_d;
      hi_q        <= hi_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_reset = cpu_reset_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule
